// File: rtl/rv32i_types.sv
// Shared RV32I types: ALU op encoding, physical tag / ROB widths and the
// ALU reservation-station entry layout.
package rv32i_types;
  localparam int PREG_W = 6;
  localparam int ROB_W  = 5;

  typedef enum logic [4:0] {
    alu_add = 5'd0,
    alu_sll = 5'd1,
    alu_sra = 5'd2,
    alu_sub = 5'd3,
    alu_xor = 5'd4,
    alu_srl = 5'd5,
    alu_or  = 5'd6,
    alu_and = 5'd7
  } alu_ops;

  typedef struct packed {
    logic              valid;
    alu_ops            aluop;
    logic [PREG_W-1:0] ps1;
    logic              rdy1;
    logic [31:0]       v1;
    logic [PREG_W-1:0] ps2;
    logic              rdy2;
    logic [31:0]       v2;
    logic [PREG_W-1:0] pd;
    logic [ROB_W-1:0]  rob;
  } alu_rs_entry_t;
endpackage

// File: rtl/alu_rs_select.sv
// Lowest-index priority picker: request vector -> one-hot grant, binary index, any.
// Purely combinational; no backpressure of its own.
module alu_rs_select #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  // Walk high to low so the lowest requesting index is written last and wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_grant    = '0;
        o_grant[i] = 1'b1;
        o_idx      = IW'(i);
        o_any      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds renamed ops until both operands are captured, then issues
// the lowest ready entry into a registered slot (1 cycle dispatch->issue); slot holds while iss_ready=0.
module alu_rs #(
  parameter int DEPTH  = 8,
  parameter int PREG_W = rv32i_types::PREG_W,
  parameter int ROB_W  = rv32i_types::ROB_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [4:0]        disp_aluop,
  input  logic [PREG_W-1:0] disp_ps1,
  input  logic              disp_rdy1,
  input  logic [31:0]       disp_v1,
  input  logic [PREG_W-1:0] disp_ps2,
  input  logic              disp_rdy2,
  input  logic [31:0]       disp_v2,
  input  logic [PREG_W-1:0] disp_pd,
  input  logic [ROB_W-1:0]  disp_rob,
  input  logic              cdb_valid,
  input  logic [PREG_W-1:0] cdb_tag,
  input  logic [31:0]       cdb_value,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [4:0]        iss_aluop,
  output logic [31:0]       iss_a,
  output logic [31:0]       iss_b,
  output logic [PREG_W-1:0] iss_pd,
  output logic [ROB_W-1:0]  iss_rob
);
  import rv32i_types::*;

  localparam int IW = $clog2(DEPTH);

  alu_rs_entry_t     r_ent [DEPTH];
  logic              r_iss_valid;
  logic [4:0]        r_iss_aluop;
  logic [31:0]       r_iss_a;
  logic [31:0]       r_iss_b;
  logic [PREG_W-1:0] r_iss_pd;
  logic [ROB_W-1:0]  r_iss_rob;

  logic [DEPTH-1:0]  w_valid;
  logic [DEPTH-1:0]  w_elig;
  logic [DEPTH-1:0]  w_iss_grant;
  logic [DEPTH-1:0]  w_free_grant_unused;
  logic [IW-1:0]     w_iss_idx;
  logic [IW-1:0]     w_free_idx;
  logic              w_iss_any;
  logic              w_free_any;
  logic              w_slot_free;
  logic              w_issue;
  logic              w_fire;
  alu_rs_entry_t     w_new;

  // Eligibility uses registered ready bits only, so same-cycle wakeups wait one cycle.
  always_comb begin
    w_valid = '0;
    w_elig  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i] = r_ent[i].valid;
      w_elig[i]  = r_ent[i].valid && r_ent[i].rdy1 && r_ent[i].rdy2;
    end
  end

  alu_rs_select #(.N(DEPTH), .IW(IW)) u_sel_iss (
    .i_req   (w_elig),
    .o_grant (w_iss_grant),
    .o_idx   (w_iss_idx),
    .o_any   (w_iss_any)
  );

  alu_rs_select #(.N(DEPTH), .IW(IW)) u_sel_free (
    .i_req   (~w_valid),
    .o_grant (w_free_grant_unused),
    .o_idx   (w_free_idx),
    .o_any   (w_free_any)
  );

  assign disp_ready  = w_free_any;
  assign w_fire      = disp_valid && w_free_any && !flush;
  assign w_slot_free = !r_iss_valid || iss_ready;
  assign w_issue     = w_slot_free && w_iss_any;

  // Incoming op, with any operand that the CDB is broadcasting this cycle already captured.
  always_comb begin
    w_new       = '0;
    w_new.valid = 1'b1;
    w_new.aluop = alu_ops'(disp_aluop);
    w_new.ps1   = disp_ps1;
    w_new.rdy1  = disp_rdy1;
    w_new.v1    = disp_v1;
    w_new.ps2   = disp_ps2;
    w_new.rdy2  = disp_rdy2;
    w_new.v2    = disp_v2;
    w_new.pd    = disp_pd;
    w_new.rob   = disp_rob;
    if (cdb_valid && !disp_rdy1 && disp_ps1 == cdb_tag) begin
      w_new.rdy1 = 1'b1;
      w_new.v1   = cdb_value;
    end
    if (cdb_valid && !disp_rdy2 && disp_ps2 == cdb_tag) begin
      w_new.rdy2 = 1'b1;
      w_new.v2   = cdb_value;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_iss_valid <= 1'b0;
      r_iss_aluop <= '0;
      r_iss_a     <= '0;
      r_iss_b     <= '0;
      r_iss_pd    <= '0;
      r_iss_rob   <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i].valid <= 1'b0;
      r_iss_valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_ent[i].valid && cdb_valid) begin
          if (!r_ent[i].rdy1 && r_ent[i].ps1 == cdb_tag) begin
            r_ent[i].rdy1 <= 1'b1;
            r_ent[i].v1   <= cdb_value;
          end
          if (!r_ent[i].rdy2 && r_ent[i].ps2 == cdb_tag) begin
            r_ent[i].rdy2 <= 1'b1;
            r_ent[i].v2   <= cdb_value;
          end
        end
        if (w_issue && w_iss_grant[i]) r_ent[i].valid <= 1'b0;
      end
      // The free pick never targets a valid entry, so this never collides with the loop above.
      if (w_fire) r_ent[w_free_idx] <= w_new;
      if (w_slot_free) begin
        r_iss_valid <= w_iss_any;
        if (w_iss_any) begin
          r_iss_aluop <= r_ent[w_iss_idx].aluop;
          r_iss_a     <= r_ent[w_iss_idx].v1;
          r_iss_b     <= r_ent[w_iss_idx].v2;
          r_iss_pd    <= r_ent[w_iss_idx].pd;
          r_iss_rob   <= r_ent[w_iss_idx].rob;
        end
      end
    end
  end

  assign iss_valid = r_iss_valid;
  assign iss_aluop = r_iss_aluop;
  assign iss_a     = r_iss_a;
  assign iss_b     = r_iss_b;
  assign iss_pd    = r_iss_pd;
  assign iss_rob   = r_iss_rob;
endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: stimulus pushes expected issues into a queue, a negedge monitor
// pops and compares on every iss_valid & iss_ready transfer.
module tb_alu_rs;
  import rv32i_types::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        disp_valid;
  logic        disp_ready;
  logic [4:0]  disp_aluop;
  logic [5:0]  disp_ps1;
  logic        disp_rdy1;
  logic [31:0] disp_v1;
  logic [5:0]  disp_ps2;
  logic        disp_rdy2;
  logic [31:0] disp_v2;
  logic [5:0]  disp_pd;
  logic [4:0]  disp_rob;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        iss_valid;
  logic        iss_ready;
  logic [4:0]  iss_aluop;
  logic [31:0] iss_a;
  logic [31:0] iss_b;
  logic [5:0]  iss_pd;
  logic [4:0]  iss_rob;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  pd;
    logic [4:0]  rob;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  alu_rs dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .disp_valid (disp_valid),
    .disp_ready (disp_ready),
    .disp_aluop (disp_aluop),
    .disp_ps1   (disp_ps1),
    .disp_rdy1  (disp_rdy1),
    .disp_v1    (disp_v1),
    .disp_ps2   (disp_ps2),
    .disp_rdy2  (disp_rdy2),
    .disp_v2    (disp_v2),
    .disp_pd    (disp_pd),
    .disp_rob   (disp_rob),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .cdb_value  (cdb_value),
    .iss_valid  (iss_valid),
    .iss_ready  (iss_ready),
    .iss_aluop  (iss_aluop),
    .iss_a      (iss_a),
    .iss_b      (iss_b),
    .iss_pd     (iss_pd),
    .iss_rob    (iss_rob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic set_disp(input logic [4:0] op, input logic [5:0] ps1, input logic r1,
                          input logic [31:0] v1, input logic [5:0] ps2, input logic r2,
                          input logic [31:0] v2, input logic [5:0] pd, input logic [4:0] rob);
    disp_valid = 1'b1;
    disp_aluop = op;
    disp_ps1   = ps1;
    disp_rdy1  = r1;
    disp_v1    = v1;
    disp_ps2   = ps2;
    disp_rdy2  = r2;
    disp_v2    = v2;
    disp_pd    = pd;
    disp_rob   = rob;
  endtask

  task automatic push(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [5:0] pd, input logic [4:0] rob);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.pd = pd; e.rob = rob;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 30 && sb.size() != 0; i++) tick();
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every slot handshake must match the oldest expected issue.
  always @(negedge clk) begin
    if (iss_valid && iss_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_issue: got op=%0d a=%h b=%h pd=%0d rob=%0d required no issue",
                 iss_aluop, iss_a, iss_b, iss_pd, iss_rob);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (iss_aluop !== e.op || iss_a !== e.a || iss_b !== e.b ||
            iss_pd !== e.pd || iss_rob !== e.rob) begin
          n_err++;
          $display("FAIL issue_payload: got op=%0d a=%h b=%h pd=%0d rob=%0d required op=%0d a=%h b=%h pd=%0d rob=%0d",
                   iss_aluop, iss_a, iss_b, iss_pd, iss_rob, e.op, e.a, e.b, e.pd, e.rob);
        end
      end
    end
  end

  initial begin
    automatic int ord[9] = '{0, 2, 1, 3, 4, 5, 6, 7, 8};
    rst_n = 1'b0; flush = 1'b0; iss_ready = 1'b0;
    disp_valid = 1'b0; disp_aluop = '0; disp_ps1 = '0; disp_rdy1 = 1'b0; disp_v1 = '0;
    disp_ps2 = '0; disp_rdy2 = 1'b0; disp_v2 = '0; disp_pd = '0; disp_rob = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
    tick(); tick();
    chk("rst_iss_valid", 32'(iss_valid), 32'd0);
    chk("rst_iss_aluop", 32'(iss_aluop), 32'd0);
    chk("rst_iss_a", iss_a, 32'd0);
    chk("rst_iss_b", iss_b, 32'd0);
    chk("rst_iss_pd", 32'(iss_pd), 32'd0);
    chk("rst_iss_rob", 32'(iss_rob), 32'd0);
    chk("rst_disp_ready", 32'(disp_ready), 32'd1);
    rst_n = 1'b1;
    iss_ready = 1'b1;

    // 1: fully ready add issues one edge after dispatch
    set_disp(alu_add, 6'd3, 1'b1, 32'd5, 6'd0, 1'b1, 32'd7, 6'd9, 5'd2);
    push(alu_add, 32'd5, 32'd7, 6'd9, 5'd2);
    tick(); disp_valid = 1'b0;
    chk("t1_not_yet", 32'(iss_valid), 32'd0);
    tick();
    chk("t1_iss_valid", 32'(iss_valid), 32'd1);
    drain("t1_drain");

    // 2: src1 woken by CDB two cycles after dispatch
    set_disp(alu_sub, 6'd12, 1'b0, 32'd0, 6'd0, 1'b1, 32'd3, 6'd10, 5'd3);
    push(alu_sub, 32'h100, 32'd3, 6'd10, 5'd3);
    tick(); disp_valid = 1'b0;
    tick();
    cdb_valid = 1'b1; cdb_tag = 6'd12; cdb_value = 32'h100;
    tick(); cdb_valid = 1'b0;
    chk("t2_not_yet", 32'(iss_valid), 32'd0);
    tick();
    chk("t2_iss_valid", 32'(iss_valid), 32'd1);
    drain("t2_drain");

    // 3: both sources captured from the CDB in the dispatch cycle
    set_disp(alu_and, 6'd4, 1'b0, 32'd0, 6'd4, 1'b0, 32'd0, 6'd11, 5'd4);
    cdb_valid = 1'b1; cdb_tag = 6'd4; cdb_value = 32'hFFFF_FFFF;
    push(alu_and, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd11, 5'd4);
    tick(); disp_valid = 1'b0; cdb_valid = 1'b0;
    chk("t3_not_yet", 32'(iss_valid), 32'd0);
    tick();
    chk("t3_iss_valid", 32'(iss_valid), 32'd1);
    drain("t3_drain");

    // 4: op0 parks in the slot, op1..op8 fill all entries (op2 reuses entry 0)
    iss_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      set_disp(alu_or, 6'd0, 1'b1, 32'h1000 + k, 6'd0, 1'b1, k * 3, 6'(20 + k), 5'(k));
      chk("t4_disp_ready_fill", 32'(disp_ready), 32'd1);
      tick();
    end
    disp_valid = 1'b0;
    for (int k = 0; k < 9; k++)
      push(alu_or, 32'h1000 + ord[k], ord[k] * 3, 6'(20 + ord[k]), 5'(ord[k]));
    chk("t4_full", 32'(disp_ready), 32'd0);
    chk("t4_slot_valid", 32'(iss_valid), 32'd1);
    chk("t4_slot_a", iss_a, 32'h1000);
    tick(); tick();
    chk("t4_hold_a", iss_a, 32'h1000);
    chk("t4_hold_pd", 32'(iss_pd), 32'd20);
    chk("t4_still_full", 32'(disp_ready), 32'd0);
    iss_ready = 1'b1;
    chk("t4_ready_same_cycle", 32'(disp_ready), 32'd0);
    tick();
    chk("t4_ready_after_issue", 32'(disp_ready), 32'd1);
    drain("t4_drain");

    // 5: flush with 5 entries valid, slot occupied and a dispatch firing
    iss_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_disp(alu_xor, 6'd0, 1'b1, 32'h2000 + k, 6'd0, 1'b1, 32'd1, 6'(40 + k), 5'(10 + k));
      tick();
    end
    chk("t5_pre_valid", 32'(iss_valid), 32'd1);
    set_disp(alu_xor, 6'd0, 1'b1, 32'h2FFF, 6'd0, 1'b1, 32'd1, 6'd50, 5'd20);
    flush = 1'b1;
    tick(); flush = 1'b0; disp_valid = 1'b0;
    chk("t5_iss_valid", 32'(iss_valid), 32'd0);
    chk("t5_disp_ready", 32'(disp_ready), 32'd1);
    iss_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t5_no_issue", 32'(iss_valid), 32'd0);
    end

    // 6: reset mid-stream (with flush and dispatch also asserted)
    iss_ready = 1'b0;
    set_disp(alu_srl, 6'd0, 1'b1, 32'hAAAA, 6'd0, 1'b1, 32'h5555, 6'd33, 5'd7);
    tick();
    set_disp(alu_sll, 6'd1, 1'b0, 32'd0, 6'd0, 1'b1, 32'd2, 6'd34, 5'd8);
    tick();
    chk("t6_pre_valid", 32'(iss_valid), 32'd1);
    rst_n = 1'b0; flush = 1'b1;
    tick(); rst_n = 1'b1; flush = 1'b0; disp_valid = 1'b0;
    chk("t6_iss_valid", 32'(iss_valid), 32'd0);
    chk("t6_iss_aluop", 32'(iss_aluop), 32'd0);
    chk("t6_iss_a", iss_a, 32'd0);
    chk("t6_iss_b", iss_b, 32'd0);
    chk("t6_iss_pd", 32'(iss_pd), 32'd0);
    chk("t6_iss_rob", 32'(iss_rob), 32'd0);
    chk("t6_disp_ready", 32'(disp_ready), 32'd1);
    iss_ready = 1'b1;
    cdb_valid = 1'b1; cdb_tag = 6'd1; cdb_value = 32'hDEAD;
    tick(); cdb_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_no_issue", 32'(iss_valid), 32'd0);
    end

    // RS keeps working after reset
    set_disp(alu_sra, 6'd2, 1'b1, 32'h8000_0000, 6'd0, 1'b1, 32'd4, 6'd5, 5'd1);
    push(alu_sra, 32'h8000_0000, 32'd4, 6'd5, 5'd1);
    tick(); disp_valid = 1'b0;
    drain("post_reset_drain");
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
